// File: rtl/tsc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the TSC CPU.
// Owns pc, the instruction register, the retired-instruction counter and the WWD output latch.
module tsc_sequencer #(
    parameter int WORD_W = 16,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_cpu,
    input  logic              cpu_enable,
    input  logic              wwd_enable,
    input  logic [WORD_W-1:0] instr,
    input  logic [WORD_W-1:0] rdat1,
    output logic [PC_W-1:0]   pc,
    output logic [WORD_W-1:0] ir,
    output logic [1:0]        rreg1,
    output logic [1:0]        rreg2,
    output logic [1:0]        wreg,
    output logic              regw,
    output logic              alus,
    output logic              lhi,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  num_inst,
    output logic [WORD_W-1:0] wwd_data,
    output logic              wwd_valid,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [WORD_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [WORD_W-1:0]   wwd_q, wwd_d;
    logic                wwd_valid_q, wwd_valid_d;

    logic [3:0] op;
    logic [5:0] func;
    logic       is_add, is_wwd, is_adi, is_lhi, is_jmp, legal;

    assign op     = ir_q[15:12];
    assign func   = ir_q[5:0];
    assign is_add = (op == 4'd15) && (func == 6'd0);
    assign is_wwd = (op == 4'd15) && (func == 6'd28);
    assign is_adi = (op == 4'd4);
    assign is_lhi = (op == 4'd6);
    assign is_jmp = (op == 4'd9);
    assign legal  = is_add | is_wwd | is_adi | is_lhi | is_jmp;

    // Register selects are pure decode of ir; they are meaningful from DECODE onward.
    assign rreg1 = ir_q[11:10];
    assign rreg2 = ir_q[9:8];
    assign wreg  = is_add ? ir_q[7:6] : ir_q[9:8];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        num_d       = num_q;
        wwd_d       = wwd_q;
        wwd_valid_d = 1'b0;
        regw        = 1'b0;
        alus        = 1'b0;
        lhi         = 1'b0;
        illegal     = 1'b0;
        if (cpu_enable) begin
            unique case (state_q)
                S_FETCH: begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    alus    = is_adi;
                    lhi     = is_lhi;
                    pc_d    = is_jmp ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
                    state_d = S_WB;
                end
                S_WB: begin
                    alus    = is_adi;
                    lhi     = is_lhi;
                    regw    = is_add | is_adi | is_lhi;
                    illegal = ~legal;
                    num_d   = num_q + CNT_W'(1);
                    if (is_wwd && wwd_enable) begin
                        wwd_d       = rdat1;
                        wwd_valid_d = 1'b1;
                    end
                    state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    // wwd_valid is refreshed every cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            num_q       <= '0;
            wwd_q       <= '0;
            wwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            num_q       <= num_d;
            wwd_q       <= wwd_d;
            wwd_valid_q <= wwd_valid_d;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign state     = state_q;
    assign num_inst  = num_q;
    assign wwd_data  = wwd_q;
    assign wwd_valid = wwd_valid_q;

endmodule
